// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and pipeline enable/flush outputs of the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] ID_RegRs;
  logic [4:0] ID_RegRt;
  logic ID_UsesRt;
  logic [4:0] EX_RegRd;
  logic EX_MemRead;
  logic EX_BranchTaken;
  logic IM_Ready;
  logic DM_Req;
  logic DM_Ready;
  logic PC_Write;
  logic IFID_Write;
  logic IFID_Flush;
  logic IDEX_Write;
  logic IDEX_Flush;
  logic EXMEM_Write;
  logic MEMWB_Write;
  logic Mem_Timeout;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Flush_Cnt;
  modport master (
    output ID_RegRs, ID_RegRt, ID_UsesRt, EX_RegRd, EX_MemRead, EX_BranchTaken,
           IM_Ready, DM_Req, DM_Ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write,
           MEMWB_Write, Mem_Timeout, Stall_Cnt, Flush_Cnt
  );
  modport slave (
    input  ID_RegRs, ID_RegRt, ID_UsesRt, EX_RegRd, EX_MemRead, EX_BranchTaken,
           IM_Ready, DM_Req, DM_Ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write,
           MEMWB_Write, Mem_Timeout, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, taken branches and memory freezes
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic mem_stall, load_use, frozen, branch, bubble;
  always_comb begin
    mem_stall = !hz.IM_Ready || (hz.DM_Req && !hz.DM_Ready);
    load_use = hz.EX_MemRead && hz.EX_RegRd != 5'd0 &&
               (hz.EX_RegRd == hz.ID_RegRs || (hz.ID_UsesRt && hz.EX_RegRd == hz.ID_RegRt));
    frozen = rst || state_q == ERROR || mem_stall;
    branch = !frozen && hz.EX_BranchTaken;
    // a squashed ID instruction cannot cause a load-use bubble
    bubble = !frozen && !hz.EX_BranchTaken && load_use;
    hz.PC_Write = !frozen && !bubble;
    hz.IFID_Write = !frozen && !bubble;
    hz.IFID_Flush = branch;
    hz.IDEX_Write = !frozen;
    hz.IDEX_Flush = branch || bubble;
    hz.EXMEM_Write = !frozen;
    hz.MEMWB_Write = !frozen;
    state_d = state_q == ERROR ? ERROR :
              !mem_stall ? RUN :
              (state_q == MEM_WAIT && wait_q == WW'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT;
    wait_d = (state_q == ERROR || !mem_stall) ? '0 : wait_q + WW'(1);
    timeout_d = timeout_q || state_d == ERROR;
    stall_cnt_d = (!hz.PC_Write && state_q != ERROR && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (branch && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    hz.Mem_Timeout = timeout_q;
    hz.Stall_Cnt = stall_cnt_q;
    hz.Flush_Cnt = flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q <= '0;
      timeout_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      timeout_q <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus randomized run against a cycle-count reference model
module tb_pipeline_hazard_ctrl;
  localparam int MT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  pipeline_hazard_ctrl_if #(.CNT_W(32)) hz();
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));
  always #5 clk = ~clk;
  bit m_err;
  int m_run;
  logic [31:0] m_stall, m_flush;
  function automatic logic [6:0] outs();
    return {hz.PC_Write, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Write, hz.IDEX_Flush, hz.EXMEM_Write, hz.MEMWB_Write};
  endfunction
  function automatic bit mstall();
    return !hz.IM_Ready || (hz.DM_Req && !hz.DM_Ready);
  endfunction
  // {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_W} from the priority rules
  function automatic logic [6:0] exp_out();
    bit lu;
    lu = hz.EX_MemRead && hz.EX_RegRd != 0 &&
         (hz.EX_RegRd == hz.ID_RegRs || (hz.ID_UsesRt && hz.EX_RegRd == hz.ID_RegRt));
    if (rst || m_err || mstall()) return 7'b0000000;
    if (hz.EX_BranchTaken) return 7'b1111111;
    if (lu) return 7'b0001111;
    return 7'b1101011;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_err <= 1'b0; m_run <= 0; m_stall <= '0; m_flush <= '0;
    end else if (!m_err) begin
      if (!exp_out()[6]) m_stall <= m_stall + 1;
      if (!mstall() && hz.EX_BranchTaken) m_flush <= m_flush + 1;
      if (mstall()) begin
        m_run <= m_run + 1;
        if (m_run + 1 == MT) m_err <= 1'b1;
      end else m_run <= 0;
    end
  end
  task automatic drive(input logic [4:0] rs, rt, rd, input logic ut, mr, br, im, dq, dr);
    hz.ID_RegRs = rs; hz.ID_RegRt = rt; hz.EX_RegRd = rd; hz.ID_UsesRt = ut;
    hz.EX_MemRead = mr; hz.EX_BranchTaken = br; hz.IM_Ready = im; hz.DM_Req = dq; hz.DM_Ready = dr;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drive(5, 5, 5, 1, 1, 1, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b0) begin errors++; $display("FAIL reset_outs got %b want 0000000", outs()); end
    checks++;
    if (hz.Stall_Cnt !== 0 || hz.Flush_Cnt !== 0 || hz.Mem_Timeout !== 1'b0) begin
      errors++; $display("FAIL reset_state got stall=%0d flush=%0d to=%b want 0 0 0", hz.Stall_Cnt, hz.Flush_Cnt, hz.Mem_Timeout);
    end
    tick();
    rst = 1'b0;
  endtask
  task automatic test_load_use();
    do_reset();
    drive(5, 7, 5, 1, 1, 0, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b0001111) begin errors++; $display("FAIL load_use_bubble got %b want 0001111", outs()); end
    tick();
    drive(8, 9, 5, 1, 0, 0, 1, 1, 1);
    #4;
    checks++;
    if (hz.Stall_Cnt !== 1) begin errors++; $display("FAIL load_use_stall_cnt got %0d want 1", hz.Stall_Cnt); end
    checks++;
    if (outs() !== 7'b1101011) begin errors++; $display("FAIL load_use_release got %b want 1101011", outs()); end
    tick();
  endtask
  task automatic test_no_stall();
    do_reset();
    drive(0, 0, 0, 1, 1, 0, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b1101011) begin errors++; $display("FAIL rd_zero got %b want 1101011", outs()); end
    tick();
    drive(3, 6, 6, 0, 1, 0, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b1101011) begin errors++; $display("FAIL rt_unused got %b want 1101011", outs()); end
    tick();
    checks++;
    if (hz.Stall_Cnt !== 0) begin errors++; $display("FAIL no_stall_cnt got %0d want 0", hz.Stall_Cnt); end
  endtask
  task automatic test_branch_lu();
    do_reset();
    drive(5, 0, 5, 0, 1, 1, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b1111111) begin errors++; $display("FAIL branch_lu got %b want 1111111", outs()); end
    tick();
    checks++;
    if (hz.Flush_Cnt !== 1 || hz.Stall_Cnt !== 0) begin
      errors++; $display("FAIL branch_lu_cnt got flush=%0d stall=%0d want 1 0", hz.Flush_Cnt, hz.Stall_Cnt);
    end
  endtask
  task automatic test_dm_freeze();
    do_reset();
    drive(1, 2, 3, 1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (outs() !== 7'b0) begin errors++; $display("FAIL dm_freeze_%0d got %b want 0000000", i, outs()); end
      tick();
    end
    hz.DM_Ready = 1'b1;
    #4;
    checks++;
    if (outs() !== 7'b1111111) begin errors++; $display("FAIL dm_release_flush got %b want 1111111", outs()); end
    tick();
    checks++;
    if (hz.Stall_Cnt !== 3 || hz.Flush_Cnt !== 1) begin
      errors++; $display("FAIL dm_cnt got stall=%0d flush=%0d want 3 1", hz.Stall_Cnt, hz.Flush_Cnt);
    end
    drive(1, 2, 3, 1, 0, 0, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b1101011 || hz.Mem_Timeout !== 1'b0) begin
      errors++; $display("FAIL dm_back_to_run got %b to=%b want 1101011 0", outs(), hz.Mem_Timeout);
    end
    tick();
  endtask
  task automatic test_timeout();
    do_reset();
    drive(1, 2, 3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < MT; i++) begin
      #4;
      checks++;
      if (outs() !== 7'b0 || hz.Mem_Timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_wait_%0d got %b to=%b want 0000000 0", i, outs(), hz.Mem_Timeout);
      end
      tick();
    end
    checks++;
    if (hz.Mem_Timeout !== 1'b1 || hz.Stall_Cnt !== MT) begin
      errors++; $display("FAIL timeout_enter got to=%b stall=%0d want 1 %0d", hz.Mem_Timeout, hz.Stall_Cnt, MT);
    end
    hz.IM_Ready = 1'b1;
    #4;
    checks++;
    if (outs() !== 7'b0) begin errors++; $display("FAIL error_frozen got %b want 0000000", outs()); end
    tick();
    checks++;
    if (hz.Stall_Cnt !== MT || hz.Mem_Timeout !== 1'b1) begin
      errors++; $display("FAIL error_hold got stall=%0d to=%b want %0d 1", hz.Stall_Cnt, hz.Mem_Timeout, MT);
    end
  endtask
  task automatic test_error_reset();
    rst = 1'b1;
    #4;
    checks++;
    if (outs() !== 7'b0 || hz.Stall_Cnt !== 0 || hz.Flush_Cnt !== 0 || hz.Mem_Timeout !== 1'b0) begin
      errors++; $display("FAIL error_reset got %b stall=%0d flush=%0d to=%b want 0000000 0 0 0",
                         outs(), hz.Stall_Cnt, hz.Flush_Cnt, hz.Mem_Timeout);
    end
    tick();
    rst = 1'b0;
    drive(4, 0, 4, 0, 1, 0, 1, 0, 0);
    #4;
    checks++;
    if (outs() !== 7'b0001111) begin errors++; $display("FAIL after_reset_run got %b want 0001111", outs()); end
    tick();
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 6) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0));
      #4;
      checks++;
      if (outs() !== exp_out()) begin errors++; $display("FAIL rand_outs cyc %0d got %b want %b", i, outs(), exp_out()); end
      checks++;
      if (hz.Stall_Cnt !== m_stall || hz.Flush_Cnt !== m_flush || hz.Mem_Timeout !== m_err) begin
        errors++; $display("FAIL rand_state cyc %0d got stall=%0d flush=%0d to=%b want %0d %0d %b",
                           i, hz.Stall_Cnt, hz.Flush_Cnt, hz.Mem_Timeout, m_stall, m_flush, m_err);
      end
      tick();
    end
    rst = 1'b0;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_lu();
    test_dm_freeze();
    test_timeout();
    test_error_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage CPU pipeline. It sits beside the forwarding logic and handles the hazards forwarding cannot cover: load-use bubbles, taken-branch flushes, and whole-pipeline freezes while instruction or data memory is not ready. It drives every pipeline-register write enable and flush, watches for a hung memory with a timeout, and keeps stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 255: consecutive memory-wait cycles allowed before the block enters the error state (≥2).
- CNT_W, 32: width of the performance counters.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ID_RegRs  in  5  rs field of the instruction in ID.
- ID_RegRt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- EX_RegRd  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_BranchTaken  in  1  branch/jump in EX resolved taken.
- IM_Ready  in  1  instruction memory returns the fetch this cycle.
- DM_Req  in  1  MEM-stage instruction accesses data memory.
- DM_Ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC register update enable.
- IFID_Write  out  1  IF/ID register write enable.
- IFID_Flush  out  1  load a NOP into IF/ID.
- IDEX_Write  out  1  ID/EX register write enable.
- IDEX_Flush  out  1  load a NOP (all control bits 0) into ID/EX.
- EXMEM_Write  out  1  EX/MEM register write enable.
- MEMWB_Write  out  1  MEM/WB register write enable.
- Mem_Timeout  out  1  sticky error flag; cleared only by rst.
- Stall_Cnt  out  CNT_W  number of cycles with PC_Write=0 while not in ERROR.
- Flush_Cnt  out  CNT_W  number of taken-branch flushes.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR.
- mem_stall = !IM_Ready || (DM_Req && !DM_Ready).
- load_use = EX_MemRead && EX_RegRd≠0 && (EX_RegRd==ID_RegRs || (ID_UsesRt && EX_RegRd==ID_RegRt)).
- Outputs are combinational from the state and the inputs. Priority, highest first:
  1. rst or ERROR: all *_Write=0, all flushes=0 (frozen).
  2. mem_stall, in RUN or MEM_WAIT: all *_Write=0, flushes=0. The pipeline is frozen, so EX_BranchTaken and load_use are held and act after release.
  3. EX_BranchTaken: all writes=1, IFID_Flush=1, IDEX_Flush=1. The PC takes the target. A coincident load_use is ignored because the ID instruction is squashed.
  4. load_use: PC_Write=0, IFID_Write=0, IDEX_Flush=1, other writes=1.
  5. Otherwise: all writes=1, flushes=0.
- Transitions:
  - RUN → MEM_WAIT when mem_stall.
  - MEM_WAIT → RUN when !mem_stall; outputs in that cycle follow rules 3–5.
  - MEM_WAIT → ERROR when mem_stall and wait_cnt==MEM_TIMEOUT-1.
  - ERROR is absorbing until rst.
- wait_cnt:
  - Counts consecutive mem_stall cycles, including the first cycle in RUN.
  - Cleared whenever mem_stall=0.
  - ERROR is entered on the edge ending the MEM_TIMEOUT-th consecutive stall cycle.
- Mem_Timeout is registered; it is 1 from the first cycle in ERROR onward.
- Stall_Cnt increments on every edge where PC_Write=0 and state≠ERROR and rst=0. It saturates at all-ones.
- Flush_Cnt increments on every edge where rule 3 fires. It saturates at all-ones.

## Timing
- Reset values: state=RUN, wait_cnt=0, Mem_Timeout=0, Stall_Cnt=0, Flush_Cnt=0. All write enables and flushes are 0 while rst=1.
- Zero-cycle latency from hazard inputs to enables/flushes, in the same cycle.
- Load-use: exactly one bubble. On the next edge the load moves to MEM and load_use drops.
- Taken branch: two-cycle penalty (the IF/ID and ID/EX slots are squashed), asserted for one cycle.
- Memory freeze lasts exactly as long as mem_stall. Nothing is lost and nothing is duplicated across the freeze.
- Reset asserted mid-wait or in ERROR returns the block to RUN and clears all state asynchronously.

## Test plan
- Load-use: lw to $5 in EX, add using $5 as rs in ID, memories ready. Required: one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1; Stall_Cnt goes 0→1; next cycle all writes=1.
- rd=0 and rt-unused: EX_RegRd=0 with a load, and separately ID_UsesRt=0 with EX_RegRd==ID_RegRt. Required: no stall in either case.
- Branch plus load-use in the same cycle. Required: IFID_Flush=IDEX_Flush=1, PC_Write=1, Flush_Cnt +1, Stall_Cnt unchanged.
- DM_Req=1 with DM_Ready=0 for 3 cycles while EX_BranchTaken=1. Required: 3 frozen cycles (all writes 0, no flush), Stall_Cnt +3, then one flush cycle; state returns to RUN.
- MEM_TIMEOUT=4, IM_Ready held 0. Required: 4 frozen cycles, then ERROR with Mem_Timeout=1; Stall_Cnt stops at 4; outputs remain frozen when IM_Ready returns to 1.
- Assert rst in ERROR for 1 cycle. Required: all outputs are at reset values, then normal RUN behaviour.
